// File: rtl/pipe_ctrl.sv
// ============================================================================
//  Module   : pipe_ctrl
//  Purpose  : RV32I 5-stage pipeline sequencing controller. Generates stalls,
//             flushes and PC redirect, and owns the debug halt/drain handshake,
//             a memory-wait timeout and a load-use bubble counter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_ctrl #(
    parameter int REG_AW       = 5,
    parameter int ADDR_W       = 32,
    parameter int DRAIN_CYCLES = 3,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1_raddr,
    input  logic [REG_AW-1:0] id_rs2_raddr,
    input  logic              id_rs1_re,
    input  logic              id_rs2_re,
    input  logic [REG_AW-1:0] ex_rd_waddr,
    input  logic              ex_rd_we,
    input  logic              ex_is_load,
    input  logic              ex_jump_req,
    input  logic [ADDR_W-1:0] ex_jump_addr,
    input  logic              mem_req,
    input  logic              mem_ready,
    input  logic              halt_req,
    output logic              pc_stall_o,
    output logic              if_id_stall_o,
    output logic              id_ex_stall_o,
    output logic              ex_mem_stall_o,
    output logic              if_id_flush_o,
    output logic              id_ex_flush_o,
    output logic              jump_o,
    output logic [ADDR_W-1:0] jump_addr_o,
    output logic              halt_ack_o,
    output logic              mem_timeout_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int WCW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [DCW-1:0] C_DRAIN_LOAD = DCW'(DRAIN_CYCLES - 1);
    localparam logic [WCW-1:0] C_WAIT_MAX   = WCW'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DCW-1:0]     drain_q, drain_d;
    logic [WCW-1:0]     wait_q, wait_d;
    logic               ack_q, ack_d;
    logic               tmo_q, tmo_d;
    logic [CNT_W-1:0]   bubble_q, bubble_d;

    logic w_mem_wait;
    logic w_load_use;
    logic w_lu_stall;
    logic w_pc_stall, w_if_id_stall, w_id_ex_stall, w_ex_mem_stall;
    logic w_if_id_flush, w_id_ex_flush, w_jump;

    assign w_mem_wait = mem_req & ~mem_ready;
    assign w_load_use = ex_is_load & ex_rd_we & (ex_rd_waddr != '0) &
                        ((id_rs1_re & (id_rs1_raddr == ex_rd_waddr)) |
                         (id_rs2_re & (id_rs2_raddr == ex_rd_waddr)));

    always_comb begin
        w_pc_stall     = 1'b0;
        w_if_id_stall  = 1'b0;
        w_id_ex_stall  = 1'b0;
        w_ex_mem_stall = 1'b0;
        w_if_id_flush  = 1'b0;
        w_id_ex_flush  = 1'b0;
        w_jump         = 1'b0;
        w_lu_stall     = 1'b0;
        if (w_mem_wait) begin
            w_pc_stall     = 1'b1;
            w_if_id_stall  = 1'b1;
            w_id_ex_stall  = 1'b1;
            w_ex_mem_stall = 1'b1;
        end else if (ex_jump_req) begin
            // The load-use consumer sits in IF/ID or ID/EX and is flushed anyway
            w_jump        = 1'b1;
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
        end else if (state_q == ST_HALTED) begin
            w_pc_stall    = 1'b1;
            w_if_id_stall = 1'b1;
            w_id_ex_flush = 1'b1;
        end else if (state_q == ST_DRAIN) begin
            w_pc_stall    = 1'b1;
            w_if_id_flush = 1'b1;
        end else if (w_load_use) begin
            w_pc_stall    = 1'b1;
            w_if_id_stall = 1'b1;
            w_id_ex_flush = 1'b1;
            w_lu_stall    = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            ST_RUN: begin
                if (halt_req && !w_mem_wait) begin
                    state_d = ST_DRAIN;
                    drain_d = C_DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (!halt_req) begin
                    state_d = ST_RUN;
                end else if (!w_mem_wait) begin
                    if (drain_q == '0) begin
                        state_d = ST_HALTED;
                    end else begin
                        drain_d = drain_q - 1'b1;
                    end
                end
            end
            ST_HALTED: begin
                if (!halt_req) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        ack_d    = (state_d == ST_HALTED);
        wait_d   = '0;
        if (w_mem_wait) begin
            wait_d = (wait_q == C_WAIT_MAX) ? wait_q : wait_q + 1'b1;
        end
        tmo_d    = tmo_q | (wait_d == C_WAIT_MAX);
        bubble_d = bubble_q;
        if (w_lu_stall && (bubble_q != '1)) begin
            bubble_d = bubble_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_RUN;
            drain_q  <= '0;
            wait_q   <= '0;
            ack_q    <= 1'b0;
            tmo_q    <= 1'b0;
            bubble_q <= '0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            wait_q   <= wait_d;
            ack_q    <= ack_d;
            tmo_q    <= tmo_d;
            bubble_q <= bubble_d;
        end
    end

    // Combinational controls are masked while reset is held low
    assign pc_stall_o     = rst & w_pc_stall;
    assign if_id_stall_o  = rst & w_if_id_stall;
    assign id_ex_stall_o  = rst & w_id_ex_stall;
    assign ex_mem_stall_o = rst & w_ex_mem_stall;
    assign if_id_flush_o  = rst & w_if_id_flush;
    assign id_ex_flush_o  = rst & w_id_ex_flush;
    assign jump_o         = rst & w_jump;
    assign jump_addr_o    = (rst & w_jump) ? ex_jump_addr : '0;
    assign halt_ack_o     = ack_q;
    assign mem_timeout_o  = tmo_q;
    assign bubble_cnt_o   = bubble_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
//  Module   : tb_pipe_ctrl
//  Purpose  : Directed scoreboard bench for pipe_ctrl.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;

    localparam logic [8:0] C_NONE = 9'b000000000;
    localparam logic [8:0] C_LU   = 9'b110001000;
    localparam logic [8:0] C_HLT  = 9'b110001000;
    localparam logic [8:0] C_WAIT = 9'b111100000;
    localparam logic [8:0] C_JMP  = 9'b000011100;
    localparam logic [8:0] C_DRN  = 9'b100010000;
    localparam logic [8:0] C_ACK  = 9'b000000010;
    localparam logic [8:0] C_TMO  = 9'b000000001;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs1_raddr, id_rs2_raddr, ex_rd_waddr;
    logic        id_rs1_re, id_rs2_re, ex_rd_we, ex_is_load, ex_jump_req;
    logic [31:0] ex_jump_addr;
    logic        mem_req, mem_ready, halt_req;
    logic        pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o;
    logic        if_id_flush_o, id_ex_flush_o, jump_o, halt_ack_o, mem_timeout_o;
    logic [31:0] jump_addr_o;
    logic [1:0]  bubble_cnt_o;

    typedef struct {
        logic [95:0] tag;
        logic [8:0]  ctl;
        logic [31:0] addr;
        logic [1:0]  bcnt;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    pipe_ctrl #(
        .REG_AW(5), .ADDR_W(32), .DRAIN_CYCLES(3), .MEM_TIMEOUT(4), .CNT_W(2)
    ) dut (
        .clk(clk), .rst(rst),
        .id_rs1_raddr(id_rs1_raddr), .id_rs2_raddr(id_rs2_raddr),
        .id_rs1_re(id_rs1_re), .id_rs2_re(id_rs2_re),
        .ex_rd_waddr(ex_rd_waddr), .ex_rd_we(ex_rd_we), .ex_is_load(ex_is_load),
        .ex_jump_req(ex_jump_req), .ex_jump_addr(ex_jump_addr),
        .mem_req(mem_req), .mem_ready(mem_ready), .halt_req(halt_req),
        .pc_stall_o(pc_stall_o), .if_id_stall_o(if_id_stall_o),
        .id_ex_stall_o(id_ex_stall_o), .ex_mem_stall_o(ex_mem_stall_o),
        .if_id_flush_o(if_id_flush_o), .id_ex_flush_o(id_ex_flush_o),
        .jump_o(jump_o), .jump_addr_o(jump_addr_o), .halt_ack_o(halt_ack_o),
        .mem_timeout_o(mem_timeout_o), .bubble_cnt_o(bubble_cnt_o)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    // Monitor: one expected entry per cycle, checked mid-cycle
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [8:0] got;
            e   = q.pop_front();
            got = {pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o,
                   if_id_flush_o, id_ex_flush_o, jump_o, halt_ack_o, mem_timeout_o};
            total++;
            if ({got, jump_addr_o, bubble_cnt_o} !== {e.ctl, e.addr, e.bcnt}) begin
                bad++;
                $display("FAIL %0s: got ctl=%b addr=%h bcnt=%0d, want ctl=%b addr=%h bcnt=%0d",
                         e.tag, got, jump_addr_o, bubble_cnt_o, e.ctl, e.addr, e.bcnt);
            end
        end
    end

    task automatic cyc(input logic [95:0] tag, input logic [8:0] ctl,
                       input logic [31:0] addr, input logic [1:0] bcnt);
        exp_t e;
        e.tag = tag; e.ctl = ctl; e.addr = addr; e.bcnt = bcnt;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic re1,
                          input logic [4:0] rs2, input logic re2);
        ex_is_load = 1'b1; ex_rd_we = 1'b1; ex_rd_waddr = rd;
        id_rs1_raddr = rs1; id_rs1_re = re1;
        id_rs2_raddr = rs2; id_rs2_re = re2;
    endtask

    task automatic clr_lu();
        ex_is_load = 1'b0; ex_rd_we = 1'b0; ex_rd_waddr = '0;
        id_rs1_raddr = '0; id_rs1_re = 1'b0;
        id_rs2_raddr = '0; id_rs2_re = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clr_lu();
        ex_jump_req = 1'b0; ex_jump_addr = '0;
        mem_req = 1'b0; mem_ready = 1'b0; halt_req = 1'b0;
        #1 rst = 1'b0;
        cyc("reset", C_NONE, 0, 0);
        rst = 1'b1;
        cyc("idle", C_NONE, 0, 0);

        // Load-use on rs1, then rd=x0, then rs2 with and without read enable
        set_lu(5, 5, 1, 0, 0);   cyc("lu_rs1", C_LU, 0, 0);
        clr_lu();                cyc("lu_done", C_NONE, 0, 1);
        set_lu(0, 0, 1, 0, 0);   cyc("lu_x0", C_NONE, 0, 1);
        set_lu(7, 0, 0, 7, 0);   cyc("lu_rs2_nore", C_NONE, 0, 1);
        set_lu(7, 0, 0, 7, 1);   cyc("lu_rs2", C_LU, 0, 1);
        clr_lu();                cyc("lu2_done", C_NONE, 0, 2);

        // Jump overrides load-use
        set_lu(5, 5, 1, 0, 0);
        ex_jump_req = 1'b1; ex_jump_addr = 32'h0000_0080;
        cyc("jmp_lu", C_JMP, 32'h80, 2);
        clr_lu(); ex_jump_req = 1'b0;
        cyc("jmp_done", C_NONE, 0, 2);

        // Short wait: no timeout
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("wait3", C_WAIT, 0, 2);
        mem_ready = 1'b1;        cyc("wait3_end", C_NONE, 0, 2);
        mem_req = 1'b0;          cyc("wait3_idle", C_NONE, 0, 2);

        // Four-cycle wait with held jump: timeout sets, jump taken on ready
        mem_req = 1'b1; mem_ready = 1'b0;
        ex_jump_req = 1'b1; ex_jump_addr = 32'h0000_0100;
        for (int i = 0; i < 4; i++) cyc("wait4_jmp", C_WAIT, 0, 2);
        mem_ready = 1'b1;        cyc("wait4_ready", C_JMP | C_TMO, 32'h100, 2);
        mem_req = 1'b0; mem_ready = 1'b0; ex_jump_req = 1'b0;
        cyc("tmo_sticky", C_NONE | C_TMO, 0, 2);

        // Full drain to halt and release
        halt_req = 1'b1;         cyc("halt_run", C_TMO, 0, 2);
        for (int i = 0; i < 3; i++) cyc("drain", C_DRN | C_TMO, 0, 2);
        cyc("halted", C_HLT | C_ACK | C_TMO, 0, 2);
        cyc("halted2", C_HLT | C_ACK | C_TMO, 0, 2);
        halt_req = 1'b0;         cyc("unhalt", C_HLT | C_ACK | C_TMO, 0, 2);
        cyc("resumed", C_TMO, 0, 2);

        // Halt dropped during drain
        halt_req = 1'b1;         cyc("h2_run", C_TMO, 0, 2);
        cyc("h2_drain", C_DRN | C_TMO, 0, 2);
        halt_req = 1'b0;         cyc("h2_drop", C_DRN | C_TMO, 0, 2);
        cyc("h2_run2", C_TMO, 0, 2);
        cyc("h2_noack", C_TMO, 0, 2);

        // Jump during drain is taken and drain keeps counting
        halt_req = 1'b1;         cyc("h3_run", C_TMO, 0, 2);
        cyc("h3_drain", C_DRN | C_TMO, 0, 2);
        ex_jump_req = 1'b1; ex_jump_addr = 32'h0000_0044;
        cyc("h3_jump", C_JMP | C_TMO, 32'h44, 2);
        ex_jump_req = 1'b0;      cyc("h3_drain2", C_DRN | C_TMO, 0, 2);
        cyc("h3_halted", C_HLT | C_ACK | C_TMO, 0, 2);
        halt_req = 1'b0;         cyc("h3_unhalt", C_HLT | C_ACK | C_TMO, 0, 2);
        cyc("h3_resumed", C_TMO, 0, 2);

        // Load-use together with halt request in RUN
        halt_req = 1'b1; set_lu(9, 9, 1, 0, 0);
        cyc("lu_halt", C_LU | C_TMO, 0, 2);
        clr_lu();                cyc("lu_halt_drn", C_DRN | C_TMO, 0, 3);
        halt_req = 1'b0;         cyc("lu_halt_drop", C_DRN | C_TMO, 0, 3);
        cyc("lu_halt_run", C_TMO, 0, 3);

        // Bubble counter saturates
        set_lu(3, 0, 0, 3, 1);   cyc("lu_sat", C_LU | C_TMO, 0, 3);
        clr_lu();                cyc("lu_sat_hold", C_TMO, 0, 3);

        // Asynchronous reset while halted
        halt_req = 1'b1;         cyc("h4_run", C_TMO, 0, 3);
        for (int i = 0; i < 3; i++) cyc("h4_drain", C_DRN | C_TMO, 0, 3);
        cyc("h4_halted", C_HLT | C_ACK | C_TMO, 0, 3);
        rst = 1'b0; halt_req = 1'b0;
        cyc("rst_async", C_NONE, 0, 0);
        cyc("rst_hold", C_NONE, 0, 0);
        rst = 1'b1;              cyc("rst_release", C_NONE, 0, 0);
        cyc("rst_run", C_NONE, 0, 0);

        repeat (2) @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain_queue: got %0d pending, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
